// File: rtl/act_order_merge16_pkg.sv
// act_pkg: shared constants for the activation order-merge block.
//   DW                 : FP16 data word width
//   ONE/LN2/INV_LN2    : FP16 constants used by the activation datapath
//   LAT_*              : pipeline latencies of the upstream activation unit
//   MODE_SOFT/MODE_EXP : issue mode encoding (1 = softplus, 0 = exp)
package act_pkg;

    localparam int DW = 16;

    localparam logic [15:0] ONE     = 16'h3C00;
    localparam logic [15:0] LN2     = 16'h398C;
    localparam logic [15:0] INV_LN2 = 16'h3DC5;

    // exp path = MUL + EXP (26 cycles); softplus path = all four (51 cycles)
    localparam int LAT_MUL   = 8;
    localparam int LAT_EXP   = 18;
    localparam int LAT_ADD   = 12;
    localparam int LAT_DIV   = 13;
    localparam int LAT_TOTAL = LAT_MUL + LAT_EXP + LAT_ADD + LAT_DIV;

    localparam logic MODE_SOFT = 1'b1;
    localparam logic MODE_EXP  = 1'b0;

endpackage

// File: rtl/act_order_merge16_if.sv
// act_order_merge16_if: issue/result/merged-stream bundle of the order merger.
//   issue_valid_i/issue_mode_i/issue_ready_o : issue notification and credit
//   s_valid_i/s_data_i, e_valid_i/e_data_i   : softplus and exp result lanes
//   m_valid_o/m_data_o/m_mode_o/m_ready_i    : merged in-order result stream
//   err_o                                    : sticky protocol-error flag
// Modports: master = issuer/lanes/consumer side, slave = the merger.
interface act_order_merge16_if #(
    parameter int DW = act_pkg::DW
);
    logic          issue_valid_i;
    logic          issue_mode_i;
    logic          issue_ready_o;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          e_valid_i;
    logic [DW-1:0] e_data_i;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_mode_o;
    logic          m_ready_i;
    logic          err_o;

    modport master (
        output issue_valid_i, issue_mode_i, s_valid_i, s_data_i,
               e_valid_i, e_data_i, m_ready_i,
        input  issue_ready_o, m_valid_o, m_data_o, m_mode_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_mode_i, s_valid_i, s_data_i,
               e_valid_i, e_data_i, m_ready_i,
        output issue_ready_o, m_valid_o, m_data_o, m_mode_o, err_o
    );
endinterface

// File: rtl/act_order_merge16_fifo.sv
// sync_fifo_fwft: first-word-fall-through synchronous FIFO.
//   clk, rst       : clock, async active-high reset (empties the FIFO)
//   push, wdata    : write strobe and data (ignored when full)
//   pop            : read strobe (ignored when empty)
//   rdata          : current head, valid whenever !empty
//   empty, full    : status flags
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointer reset makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/act_order_merge16.sv
// act_order_merge16: restores issue order between the softplus and exp
// result lanes of the activation unit.
//   clk, rst : clock, async active-high reset
//   bus      : act_order_merge16_if.slave (issue, s/e lanes, merged stream, err)
// Optional macro ACT_MERGE_STATS_EN adds:
//   stat_soft_o / stat_exp_o : merged pops per mode (32-bit, wrapping)
//   stat_maxocc_o            : peak order-FIFO occupancy
module act_order_merge16
    import act_pkg::*;
#(
    parameter int DW    = act_pkg::DW,
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    act_order_merge16_if.slave bus
`ifdef ACT_MERGE_STATS_EN
    ,
    output logic [31:0]              stat_soft_o,
    output logic [31:0]              stat_exp_o,
    output logic [$clog2(DEPTH):0]   stat_maxocc_o
`endif
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          ord_push, ord_pop, ord_rdata, ord_empty, ord_full;
    logic          s_push, s_pop, s_empty, s_full;
    logic          e_push, e_pop, e_empty, e_full;
    logic [DW-1:0] s_rdata, e_rdata;
    logic [PW-1:0] pend_s, pend_e;
    logic          iss_soft, iss_exp;
    logic          head_soft, m_valid, m_fire;
    logic          err_q, err_set;

    assign ord_push = bus.issue_valid_i && !ord_full;
    assign iss_soft = ord_push && (bus.issue_mode_i == MODE_SOFT);
    assign iss_exp  = ord_push && (bus.issue_mode_i == MODE_EXP);

    // A lane result is only accepted if one is outstanding on that lane.
    assign s_push = bus.s_valid_i && (pend_s != '0) && !s_full;
    assign e_push = bus.e_valid_i && (pend_e != '0) && !e_full;

    assign head_soft = (ord_rdata == MODE_SOFT);
    assign m_valid   = !ord_empty && (head_soft ? !s_empty : !e_empty);
    assign m_fire    = m_valid && bus.m_ready_i;
    assign ord_pop   = m_fire;
    assign s_pop     = m_fire && head_soft;
    assign e_pop     = m_fire && !head_soft;

    assign err_set = (bus.issue_valid_i && ord_full) ||
                     (bus.s_valid_i && !s_push) ||
                     (bus.e_valid_i && !e_push);

    sync_fifo_fwft #(.WIDTH(1), .DEPTH(DEPTH)) u_order (
        .clk(clk), .rst(rst), .push(ord_push), .wdata(bus.issue_mode_i),
        .pop(ord_pop), .rdata(ord_rdata), .empty(ord_empty), .full(ord_full)
    );

    sync_fifo_fwft #(.WIDTH(DW), .DEPTH(DEPTH)) u_soft (
        .clk(clk), .rst(rst), .push(s_push), .wdata(bus.s_data_i),
        .pop(s_pop), .rdata(s_rdata), .empty(s_empty), .full(s_full)
    );

    sync_fifo_fwft #(.WIDTH(DW), .DEPTH(DEPTH)) u_exp (
        .clk(clk), .rst(rst), .push(e_push), .wdata(bus.e_data_i),
        .pop(e_pop), .rdata(e_rdata), .empty(e_empty), .full(e_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_s <= '0;
            pend_e <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_s <= pend_s + PW'(iss_soft) - PW'(s_push);
            pend_e <= pend_e + PW'(iss_exp)  - PW'(e_push);
            err_q  <= err_q | err_set;
        end
    end

    // Data/mode are forced to zero when nothing is presentable so the
    // outputs never expose stale FIFO storage.
    assign bus.issue_ready_o = !ord_full;
    assign bus.m_valid_o     = m_valid;
    assign bus.m_mode_o      = ord_empty ? 1'b0 : ord_rdata;
    assign bus.m_data_o      = !m_valid ? '0 : (head_soft ? s_rdata : e_rdata);
    assign bus.err_o         = err_q;

`ifdef ACT_MERGE_STATS_EN
    logic [PW-1:0] occ, occ_next;

    assign occ_next = occ + PW'(ord_push) - PW'(ord_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ           <= '0;
            stat_soft_o   <= '0;
            stat_exp_o    <= '0;
            stat_maxocc_o <= '0;
        end else begin
            occ <= occ_next;
            if (s_pop) stat_soft_o <= stat_soft_o + 32'd1;
            if (e_pop) stat_exp_o  <= stat_exp_o + 32'd1;
            if (occ_next > stat_maxocc_o) stat_maxocc_o <= occ_next;
        end
    end
`endif
endmodule

// File: tb/tb_act_order_merge16.sv
// Directed testbench for act_order_merge16.
module tb_act_order_merge16;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    logic [16:0] got_v[$];
    int          got_t[$];

    always #5 clk = ~clk;

    act_order_merge16_if #(.DW(16)) bus ();

`ifdef ACT_MERGE_STATS_EN
    logic [31:0] stat_soft, stat_exp;
    logic [6:0]  stat_maxocc;
`endif

    act_order_merge16 #(.DW(16), .DEPTH(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ACT_MERGE_STATS_EN
        ,
        .stat_soft_o(stat_soft),
        .stat_exp_o(stat_exp),
        .stat_maxocc_o(stat_maxocc)
`endif
    );

    task automatic clr_in();
        bus.issue_valid_i = 1'b0;
        bus.issue_mode_i  = 1'b0;
        bus.s_valid_i     = 1'b0;
        bus.s_data_i      = 16'h0;
        bus.e_valid_i     = 1'b0;
        bus.e_data_i      = 16'h0;
    endtask

    // One clock: record a pop at the falling edge, then step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (bus.m_valid_o && bus.m_ready_i) begin
            got_v.push_back({bus.m_mode_o, bus.m_data_o});
            got_t.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        clr_in();
        bus.m_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_n = 0;
        got_v.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        clr_in();
        bus.m_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid_o); end
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", bus.issue_ready_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
        checks++; if (bus.m_data_o !== 16'h0) begin errors++; $display("FAIL reset_m_data got %h exp 0000", bus.m_data_o); end
        checks++; if (bus.m_mode_o !== 1'b0) begin errors++; $display("FAIL reset_m_mode got %b exp 0", bus.m_mode_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // exp issued first, softplus 51 cycles later; results arrive in order.
    task automatic test_in_order();
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 106; c++) begin
            clr_in();
            if (c == 0)   begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b0; end
            if (c == 26)  begin bus.e_valid_i = 1'b1; bus.e_data_i = 16'h3C00; end
            if (c == 51)  begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b1; end
            if (c == 102) begin bus.s_valid_i = 1'b1; bus.s_data_i = 16'h398C; end
            cyc();
        end
        clr_in();
        checks++; if (got_v.size() !== 2) begin errors++; $display("FAIL inorder_count got %0d exp 2", got_v.size()); end
        else begin
            checks++; if (got_v[0] !== 17'h03C00) begin errors++; $display("FAIL inorder_first got %h exp 03c00", got_v[0]); end
            checks++; if (got_v[1] !== 17'h1398C) begin errors++; $display("FAIL inorder_second got %h exp 1398c", got_v[1]); end
            checks++; if (got_t[0] !== 27) begin errors++; $display("FAIL inorder_latency got %0d exp 27", got_t[0]); end
            checks++; if (got_t[1] !== 103) begin errors++; $display("FAIL inorder_latency2 got %0d exp 103", got_t[1]); end
        end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL inorder_err got %b exp 0", bus.err_o); end
    endtask

    // softplus then exp back to back; exp result arrives first and must wait.
    task automatic test_out_of_order();
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            clr_in();
            if (c == 0)  begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b1; end
            if (c == 1)  begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b0; end
            if (c == 27) begin bus.e_valid_i = 1'b1; bus.e_data_i = 16'h3C00; end
            if (c == 51) begin bus.s_valid_i = 1'b1; bus.s_data_i = 16'h398C; end
            cyc();
            if (c == 40) begin
                checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_blocked got %b exp 0", bus.m_valid_o); end
            end
        end
        clr_in();
        checks++; if (got_v.size() !== 2) begin errors++; $display("FAIL ooo_count got %0d exp 2", got_v.size()); end
        else begin
            checks++; if (got_v[0] !== 17'h1398C) begin errors++; $display("FAIL ooo_first got %h exp 1398c", got_v[0]); end
            checks++; if (got_v[1] !== 17'h03C00) begin errors++; $display("FAIL ooo_second got %h exp 03c00", got_v[1]); end
            checks++; if (got_t[0] !== 52) begin errors++; $display("FAIL ooo_time got %0d exp 52", got_t[0]); end
        end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ooo_err got %b exp 0", bus.err_o); end
    endtask

    // Output must hold while the consumer stalls.
    task automatic test_hold();
        do_reset();
        bus.m_ready_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            clr_in();
            if (c == 0) begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b0; end
            if (c == 2) begin bus.e_valid_i = 1'b1; bus.e_data_i = 16'hABCD; end
            cyc();
            if (c >= 3) begin
                checks++;
                if ({bus.m_valid_o, bus.m_mode_o, bus.m_data_o} !== {1'b1, 1'b0, 16'hABCD}) begin
                    errors++; $display("FAIL hold_stable c=%0d got %b %b %h exp 1 0 abcd", c, bus.m_valid_o, bus.m_mode_o, bus.m_data_o);
                end
            end
        end
        bus.m_ready_i = 1'b1;
        cyc();
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL hold_drained got %b exp 0", bus.m_valid_o); end
        checks++; if (got_v.size() !== 1) begin errors++; $display("FAIL hold_pops got %0d exp 1", got_v.size()); end
    endtask

    // Fill the order FIFO, overflow once, then drain all 64.
    task automatic test_full();
        int bad;
        do_reset();
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            clr_in();
            bus.issue_valid_i = 1'b1;
            bus.issue_mode_i  = 1'b0;
            cyc();
        end
        clr_in();
        checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.issue_ready_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL full_err_early got %b exp 0", bus.err_o); end
        bus.issue_valid_i = 1'b1;
        cyc();
        clr_in();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL overflow_err got %b exp 1", bus.err_o); end
        checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL overflow_ready got %b exp 0", bus.issue_ready_o); end
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 70; i++) begin
            clr_in();
            if (i < 64) begin bus.e_valid_i = 1'b1; bus.e_data_i = 16'(i); end
            cyc();
        end
        clr_in();
        checks++; if (got_v.size() !== 64) begin errors++; $display("FAIL full_drain_count got %0d exp 64", got_v.size()); end
        bad = 0;
        foreach (got_v[k]) if (got_v[k] !== {1'b0, 16'(k)}) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_drain_data got %0d bad entries exp 0", bad); end
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL full_drain_empty got %b exp 0", bus.m_valid_o); end
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_drain_ready got %b exp 1", bus.issue_ready_o); end
    endtask

    // Both lanes deliver in the same cycle.
    task automatic test_simultaneous();
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            clr_in();
            if (c == 0) begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b1; end
            if (c == 1) begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b0; end
            if (c == 3) begin
                bus.s_valid_i = 1'b1; bus.s_data_i = 16'h1111;
                bus.e_valid_i = 1'b1; bus.e_data_i = 16'h2222;
            end
            cyc();
        end
        clr_in();
        checks++; if (got_v.size() !== 2) begin errors++; $display("FAIL simul_count got %0d exp 2", got_v.size()); end
        else begin
            checks++; if (got_v[0] !== 17'h11111) begin errors++; $display("FAIL simul_first got %h exp 11111", got_v[0]); end
            checks++; if (got_v[1] !== 17'h02222) begin errors++; $display("FAIL simul_second got %h exp 02222", got_v[1]); end
        end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL simul_err got %b exp 0", bus.err_o); end
    endtask

    // Lane valids with nothing pending on that lane.
    task automatic test_unexpected();
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clr_in();
            if (c == 0) begin bus.s_valid_i = 1'b1; bus.s_data_i = 16'h5555; end
            cyc();
        end
        clr_in();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL unexp_s_err got %b exp 1", bus.err_o); end
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL unexp_s_valid got %b exp 0", bus.m_valid_o); end
        checks++; if (got_v.size() !== 0) begin errors++; $display("FAIL unexp_s_pops got %0d exp 0", got_v.size()); end
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clr_in();
            if (c == 0) begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = 1'b1; end
            if (c == 2) begin bus.e_valid_i = 1'b1; bus.e_data_i = 16'h7777; end
            cyc();
        end
        clr_in();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL unexp_e_err got %b exp 1", bus.err_o); end
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL unexp_e_valid got %b exp 0", bus.m_valid_o); end
    endtask

    // Reset with 10 outstanding issues and some buffered results.
    task automatic test_reset_midstream();
        do_reset();
        bus.m_ready_i = 1'b0;
        for (int c = 0; c < 13; c++) begin
            clr_in();
            if (c < 10) begin bus.issue_valid_i = 1'b1; bus.issue_mode_i = c[0]; end
            if (c >= 10) begin
                bus.e_valid_i = 1'b1; bus.e_data_i = 16'h4000 + 16'(c);
                bus.s_valid_i = (c != 12); bus.s_data_i = 16'h5000 + 16'(c);
            end
            cyc();
        end
        clr_in();
        checks++; if ({bus.m_valid_o, bus.m_data_o} !== {1'b1, 16'h400A}) begin errors++; $display("FAIL mid_pre got %b %h exp 1 400a", bus.m_valid_o, bus.m_data_o); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.m_valid_o); end
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", bus.issue_ready_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b exp 0", bus.err_o); end
        checks++; if ({bus.m_mode_o, bus.m_data_o} !== 17'h0) begin errors++; $display("FAIL mid_rst_data got %b %h exp 0 0000", bus.m_mode_o, bus.m_data_o); end
        rst = 1'b0;
        bus.m_ready_i = 1'b1;
        bus.e_valid_i = 1'b1;
        bus.e_data_i  = 16'h3C00;
        cyc();
        clr_in();
        cyc();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL mid_late_err got %b exp 1", bus.err_o); end
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL mid_late_valid got %b exp 0", bus.m_valid_o); end
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        bus.m_ready_i = 1'b0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_hold();
        test_full();
        test_simultaneous();
        test_unexpected();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
